// File: rtl/bootrom_ctrl_pkg.sv
// Shared definitions for the boot ROM AHB-Lite controller: FSM state
// encoding, AHB transfer-type and response encodings.
package bootrom_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic is_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/bootrom_ahb_ctrl.sv
// AHB-Lite read-only slave in front of the boot ROM wrapper: one-cycle ROM
// enable per miss, programmable wait states, one-word last-read buffer.
module bootrom_ahb_ctrl
    import bootrom_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0,
    parameter int BUF_EN      = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              ROM_EN,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [31:0]       ROM_RDATA
);

    localparam logic [2:0] WS_C = 3'(WAIT_STATES);

    state_e              state_r;
    state_e              state_d;
    logic [2:0]          cnt_r;
    logic [2:0]          cnt_d;
    logic [ADDR_W-1:0]   addr_q_r;
    logic                buf_valid_r;
    logic [ADDR_W-1:0]   buf_tag_r;
    logic [31:0]         buf_data_r;
    logic                hreadyout_r;
    logic                hresp_r;
    logic                rom_en_r;

    logic                hreadyout_d;
    logic                hresp_d;
    logic                rom_en_d;
    logic                latch_s;
    logic                accept_s;
    logic                hit_s;
    logic                eff_valid_s;
    logic [ADDR_W-1:0]   eff_tag_s;
    logic [ADDR_W-1:0]   word_addr_s;
    logic                unused_s;

    assign unused_s    = ^{HSIZE, HADDR[31:ADDR_W+2], HADDR[1:0]};
    assign word_addr_s = HADDR[ADDR_W+1:2];
    assign accept_s    = HSEL & HREADY & is_active(HTRANS);

    // During RESP the buffer is being refilled this cycle, so compare
    // against the incoming tag to let a back-to-back read of the same word hit.
    assign eff_valid_s = (state_r == ST_RESP) | buf_valid_r;
    assign eff_tag_s   = (state_r == ST_RESP) ? addr_q_r : buf_tag_r;
    assign hit_s       = (BUF_EN != 0) & eff_valid_s & (word_addr_s == eff_tag_s);

    // Next-state, wait counter and registered-output decode.
    always_comb begin
        state_d = state_r;
        cnt_d   = cnt_r;
        latch_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_RESP, ST_ERR2: begin
                if (accept_s) begin
                    if (HWRITE) begin
                        state_d = ST_ERR1;
                    end else if (hit_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACCESS;
                        latch_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (WS_C != 3'd0) begin
                    state_d = ST_WAIT;
                    cnt_d   = WS_C;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_r - 3'd1;
                if (cnt_r == 3'd1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        hreadyout_d = !((state_d == ST_ACCESS) || (state_d == ST_WAIT) || (state_d == ST_ERR1));
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        rom_en_d    = (state_d == ST_ACCESS);
    end

    // State, buffer and output registers; synchronous reset abandons any transfer.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            addr_q_r    <= '0;
            buf_valid_r <= 1'b0;
            buf_tag_r   <= '0;
            buf_data_r  <= 32'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
            rom_en_r    <= 1'b0;
        end else begin
            state_r     <= state_d;
            cnt_r       <= cnt_d;
            hreadyout_r <= hreadyout_d;
            hresp_r     <= hresp_d;
            rom_en_r    <= rom_en_d;
            if (latch_s) begin
                addr_q_r <= word_addr_s;
            end
            if (state_r == ST_RESP) begin
                buf_valid_r <= 1'b1;
                buf_tag_r   <= addr_q_r;
                buf_data_r  <= ROM_RDATA;
            end
        end
    end

    // ROM data is only valid to the bus in RESP; otherwise the buffer is shown.
    assign HRDATA    = (state_r == ST_RESP) ? ROM_RDATA : buf_data_r;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign ROM_EN    = rom_en_r;
    assign ROM_ADDR  = addr_q_r;

endmodule

// File: tb/tb_bootrom_ahb_ctrl.sv
// Directed bench: three controller instances (default, buffer disabled,
// three wait states), each with its own behavioural ROM.
module tb_bootrom_ahb_ctrl;
    import bootrom_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel_b;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    int          cur;
    int          errors = 0;
    int          checks = 0;

    logic        hsel_a      [3];
    logic        hready_a    [3];
    logic        hreadyout_a [3];
    logic        hresp_a     [3];
    logic        rom_en_a    [3];
    logic [31:0] hrdata_a    [3];
    logic [31:0] rom_rdata_a [3];
    logic [7:0]  rom_addr_a  [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        assign hsel_a[k]   = hsel_b && (cur == k);
        assign hready_a[k] = hreadyout_a[k];
        bootrom_ahb_ctrl #(
            .ADDR_W(8),
            .WAIT_STATES((k == 2) ? 3 : 0),
            .BUF_EN((k == 1) ? 0 : 1)
        ) u_dut (
            .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_a[k]), .HADDR(haddr),
            .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HREADY(hready_a[k]),
            .HREADYOUT(hreadyout_a[k]), .HRESP(hresp_a[k]), .HRDATA(hrdata_a[k]),
            .ROM_EN(rom_en_a[k]), .ROM_ADDR(rom_addr_a[k]), .ROM_RDATA(rom_rdata_a[k])
        );
    end

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        if (a == 8'd4) return 32'hDEAD_BEEF;
        else return {16'hC0DE, 8'h00, a};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rom_en_a[k]) rom_rdata_a[k] <= rom_word(rom_addr_a[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        hsel_b = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Drives one address phase in the current cycle and follows it to its data phase.
    task automatic xfer(input logic [31:0] addr, input logic wr, output int waits,
                        output logic [31:0] data, output logic resp, output logic resp1,
                        output int en_n, output logic [7:0] en_addr);
        hsel_b = 1'b1; haddr = addr; htrans = HTRANS_NONSEQ; hwrite = wr;
        step();
        hsel_b = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        waits = 0; en_n = 0; en_addr = 8'h00;
        resp1 = hresp_a[cur];
        for (int i = 0; i < 20; i++) begin
            if (rom_en_a[cur]) begin en_n++; en_addr = rom_addr_a[cur]; end
            if (hreadyout_a[cur]) break;
            waits++;
            step();
        end
        data = hrdata_a[cur];
        resp = hresp_a[cur];
    endtask

    task automatic test_reset();
        cur = 0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        checks++; if (hreadyout_a[0] !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b want 1", hreadyout_a[0]); end
        checks++; if (hresp_a[0] !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", hresp_a[0]); end
        checks++; if (hrdata_a[0] !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", hrdata_a[0]); end
        checks++; if (rom_en_a[0] !== 1'b0) begin errors++; $display("FAIL reset_rom_en: got %b want 0", rom_en_a[0]); end
        checks++; if (rom_addr_a[0] !== 8'h00) begin errors++; $display("FAIL reset_rom_addr: got %h want 00", rom_addr_a[0]); end
    endtask

    task automatic test_single_read();
        int w, n; logic [31:0] d; logic r, r1; logic [7:0] ea;
        cur = 0;
        xfer(32'h0000_0010, 1'b0, w, d, r, r1, n, ea);
        checks++; if (w !== 1) begin errors++; $display("FAIL single_waits: got %0d want 1", w); end
        checks++; if (n !== 1) begin errors++; $display("FAIL single_en_pulses: got %0d want 1", n); end
        checks++; if (ea !== 8'h04) begin errors++; $display("FAIL single_rom_addr: got %h want 04", ea); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", d); end
        checks++; if (r !== 1'b0) begin errors++; $display("FAIL single_resp: got %b want 0", r); end
    endtask

    task automatic test_back_to_back();
        int w, n; logic [31:0] d; logic r, r1; logic [7:0] ea;
        cur = 0;
        pulse_reset();
        xfer(32'h10, 1'b0, w, d, r, r1, n, ea);
        xfer(32'h10, 1'b0, w, d, r, r1, n, ea);
        checks++; if (w !== 0) begin errors++; $display("FAIL b2b_hit_waits: got %0d want 0", w); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_hit_data: got %h want deadbeef", d); end
        checks++; if (n !== 0) begin errors++; $display("FAIL b2b_hit_en: got %0d want 0", n); end
        step();
        cur = 1;
        xfer(32'h10, 1'b0, w, d, r, r1, n, ea);
        checks++; if (n !== 1 || w !== 1) begin errors++; $display("FAIL nobuf_first: got en=%0d waits=%0d want en=1 waits=1", n, w); end
        xfer(32'h10, 1'b0, w, d, r, r1, n, ea);
        checks++; if (n !== 1 || w !== 1) begin errors++; $display("FAIL nobuf_second: got en=%0d waits=%0d want en=1 waits=1", n, w); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nobuf_data: got %h want deadbeef", d); end
        step();
    endtask

    task automatic test_write_error();
        int w, n; logic [31:0] d; logic r, r1; logic [7:0] ea;
        cur = 0;
        xfer(32'h20, 1'b1, w, d, r, r1, n, ea);
        checks++; if (w !== 1) begin errors++; $display("FAIL err_waits: got %0d want 1", w); end
        checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL err1_resp: got %b want 1", r1); end
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL err2_resp: got %b want 1", r); end
        checks++; if (n !== 0) begin errors++; $display("FAIL err_rom_en: got %0d want 0", n); end
        xfer(32'h20, 1'b0, w, d, r, r1, n, ea);
        checks++; if (d !== 32'hC0DE_0008) begin errors++; $display("FAIL after_err_data: got %h want c0de0008", d); end
        checks++; if (n !== 1 || ea !== 8'h08) begin errors++; $display("FAIL after_err_rom: got en=%0d addr=%h want en=1 addr=08", n, ea); end
        checks++; if (r !== 1'b0) begin errors++; $display("FAIL after_err_resp: got %b want 0", r); end
    endtask

    task automatic test_idle_busy();
        int w, n; logic [31:0] d; logic r, r1; logic [7:0] ea;
        cur = 0;
        hsel_b = 1'b1; haddr = 32'h40; hwrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hsel_b = (i != 2);
            htrans = (i == 0) ? HTRANS_IDLE : ((i == 1) ? HTRANS_BUSY : HTRANS_NONSEQ);
            step();
            checks++;
            if (hreadyout_a[0] !== 1'b1 || hresp_a[0] !== 1'b0 || rom_en_a[0] !== 1'b0) begin
                errors++;
                $display("FAIL idle_busy_%0d: got ready=%b resp=%b en=%b want 1 0 0", i, hreadyout_a[0], hresp_a[0], rom_en_a[0]);
            end
        end
        hsel_b = 1'b0; htrans = HTRANS_IDLE;
        xfer(32'h20, 1'b0, w, d, r, r1, n, ea);
        checks++; if (w !== 0 || n !== 0) begin errors++; $display("FAIL idle_keep_hit: got waits=%0d en=%0d want 0 0", w, n); end
        checks++; if (d !== 32'hC0DE_0008) begin errors++; $display("FAIL idle_keep_data: got %h want c0de0008", d); end
    endtask

    task automatic test_wait_wrap();
        int w, n; logic [31:0] d; logic r, r1; logic [7:0] ea;
        cur = 2;
        step();
        xfer(32'h3FC, 1'b0, w, d, r, r1, n, ea);
        checks++; if (w !== 4) begin errors++; $display("FAIL ws3_waits: got %0d want 4", w); end
        checks++; if (n !== 1 || ea !== 8'hFF) begin errors++; $display("FAIL ws3_rom: got en=%0d addr=%h want en=1 addr=ff", n, ea); end
        checks++; if (d !== 32'hC0DE_00FF) begin errors++; $display("FAIL ws3_data: got %h want c0de00ff", d); end
        xfer(32'h400, 1'b0, w, d, r, r1, n, ea);
        checks++; if (n !== 1 || ea !== 8'h00) begin errors++; $display("FAIL wrap_rom: got en=%0d addr=%h want en=1 addr=00", n, ea); end
        checks++; if (d !== 32'hC0DE_0000 || w !== 4) begin errors++; $display("FAIL wrap_data: got %h waits=%0d want c0de0000 waits=4", d, w); end
        step();
    endtask

    task automatic test_reset_mid_wait();
        int w, n; logic [31:0] d; logic r, r1; logic [7:0] ea;
        cur = 2;
        hsel_b = 1'b1; haddr = 32'h404; htrans = HTRANS_NONSEQ; hwrite = 1'b0;
        step();
        hsel_b = 1'b0; htrans = HTRANS_IDLE;
        step();
        checks++; if (hreadyout_a[2] !== 1'b0) begin errors++; $display("FAIL mid_wait_busy: got %b want 0", hreadyout_a[2]); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (hreadyout_a[2] !== 1'b1 || hresp_a[2] !== 1'b0) begin errors++; $display("FAIL rst_wait_bus: got ready=%b resp=%b want 1 0", hreadyout_a[2], hresp_a[2]); end
        checks++; if (rom_en_a[2] !== 1'b0 || hrdata_a[2] !== 32'h0) begin errors++; $display("FAIL rst_wait_rom: got en=%b data=%h want 0 0", rom_en_a[2], hrdata_a[2]); end
        xfer(32'h0, 1'b0, w, d, r, r1, n, ea);
        checks++; if (w !== 4 || n !== 1) begin errors++; $display("FAIL rst_buf_miss: got waits=%0d en=%0d want 4 1", w, n); end
        checks++; if (d !== 32'hC0DE_0000) begin errors++; $display("FAIL rst_buf_data: got %h want c0de0000", d); end
    endtask

    initial begin
        rst_n = 1'b0; hsel_b = 1'b0; haddr = 32'h0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = 3'b010; cur = 0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write_error();
        test_idle_busy();
        test_wait_wrap();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
